// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the subordinate FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HALF  = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } slv_state_e;

endpackage

// File: rtl/ahb_wstrb_gen.sv
// Little-endian byte-enable generator from address low bits and hsize.
// Oversized hsize saturates to a full-width access.
module ahb_wstrb_gen #(
  parameter  int AHB_DW = 32,
  localparam int NB     = AHB_DW / 8,
  localparam int LW     = $clog2(NB)
) (
  input  logic [LW-1:0] addr_lo,
  input  logic [2:0]    hsize,
  output logic [NB-1:0] wstrb
);

  logic [2:0]    size_eff;
  logic [LW-1:0] off;
  logic [NB-1:0] lanes;

  always_comb begin
    size_eff = (hsize > 3'(LW)) ? 3'(LW) : hsize;
    // low offset bits forced to zero to honour the transfer's natural alignment
    off      = addr_lo & ~LW'((1 << size_eff) - 1);
    lanes    = NB'((1 << (1 << size_eff)) - 1);
    wstrb    = lanes << off;
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite subordinate backed by a word-addressed memory with a fixed
// number of wait states per transfer; every response is OKAY.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int AHB_DW      = 32,
  parameter int AHB_AW      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hsel,
  input  logic [AHB_AW-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [AHB_DW-1:0] hwdata,
  output logic [AHB_DW-1:0] hrdata,
  output logic              hready
);

  localparam int         NB = AHB_DW / 8;
  localparam int         LW = $clog2(NB);
  localparam int         IW = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  slv_state_e    state_q, state_d;
  logic          hready_q, hready_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          hwrite_q, hwrite_d;
  logic [2:0]    hsize_q, hsize_d;

  logic [AHB_DW-1:0] mem [MEM_DEPTH];
  logic [NB-1:0]     wstrb;
  logic              accept;
  logic              unused_in;

  // hburst is never decoded: each beat carries its own address
  assign unused_in = ^{hburst, htrans[0], haddr[AHB_AW-1:LW+IW]};
  assign accept    = hsel & hready_q & htrans[1];

  always_comb begin
    state_d  = state_q;
    hready_d = hready_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          idx_d    = haddr[LW +: IW];
          lane_d   = haddr[LW-1:0];
          hwrite_d = hwrite;
          hsize_d  = hsize;
          if (WAIT_STATES == 0) begin
            state_d  = S_RESP;
            hready_d = 1'b1;
          end else begin
            state_d  = S_WAIT;
            hready_d = 1'b0;
            cnt_d    = WS - 4'd1;
          end
        end else begin
          state_d  = S_IDLE;
          hready_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RESP;
          hready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        hready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      hready_q <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
    end else begin
      state_q  <= state_d;
      hready_q <= hready_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lane_q   <= lane_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
    end
  end

  ahb_wstrb_gen #(.AHB_DW(AHB_DW)) u_wstrb (
    .addr_lo (lane_q),
    .hsize   (hsize_q),
    .wstrb   (wstrb)
  );

  // Memory has no reset; a reset clears state_q first, which drops any pending write.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && hwrite_q) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = (state_q == S_RESP && !hwrite_q) ? mem[idx_q] : '0;
  assign hready = hready_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench: a zero-wait and a three-wait instance share one master bus.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = 2'd0;
  logic [2:0]  hsize = 3'd2, hburst = 3'd0;
  logic        hsel0, hsel3, hready0, hready3, hready_m;
  logic [31:0] hrdata0, hrdata3, hrdata_m;

  int checks = 0, fails = 0, cyc = 0, lowcnt = 0;
  logic        pend_rd = 1'b0;
  logic [31:0] pend_wd = '0;
  logic [31:0] mdl [2][256];
  logic [31:0] exp_q[$], obs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign hsel0    = hsel & ~sel;
  assign hsel3    = hsel & sel;
  assign hready_m = sel ? hready3 : hready0;
  assign hrdata_m = sel ? hrdata3 : hrdata0;

  ahb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata0), .hready(hready0)
  );

  ahb_slave_mem #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata3), .hready(hready3)
  );

  // One address phase; the previous beat's data phase completes alongside it.
  task automatic issue(input logic s, input logic [1:0] tr, input logic wr,
                       input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n = 0;
    int t = sel ? 1 : 0;
    int idx, szn, nb, off;
    hsel = s; htrans = tr; hwrite = wr; haddr = a; hsize = sz; hwdata = pend_wd;
    forever begin
      @(negedge clk);
      if (hready_m) begin
        if (pend_rd) obs_q.push_back(hrdata_m);
        break;
      end
      lowcnt++; n++;
      if (n > 64) begin
        checks++; fails++;
        $display("FAIL hready_timeout: hready low for %0d cycles, required at most 64", n);
        break;
      end
    end
    @(posedge clk); #1;
    pend_rd = s && tr[1] && !wr;
    pend_wd = wd;
    if (s && tr[1]) begin
      idx = int'((a >> 2) & 32'hFF);
      szn = (sz > 3'd2) ? 2 : int'(sz);
      nb  = 1 << szn;
      off = int'(a[1:0]) & ~(nb - 1);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (b >= off && b < off + nb) mdl[t][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_q.push_back(mdl[t][idx]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hready0 !== 1'b1) begin fails++; $display("FAIL reset_hready0: got %b required 1", hready0); end
    checks++; if (hready3 !== 1'b1) begin fails++; $display("FAIL reset_hready3: got %b required 1", hready3); end
    checks++; if (hrdata0 !== 32'h0) begin fails++; $display("FAIL reset_hrdata0: got %h required 0", hrdata0); end
    checks++; if (hrdata3 !== 32'h0) begin fails++; $display("FAIL reset_hrdata3: got %h required 0", hrdata3); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait();
    sel = 1'b0; lowcnt = 0;
    issue(1, NONSEQ, 1, 32'h10, WORD, 32'hDEADBEEF);
    issue(1, NONSEQ, 0, 32'h10, WORD, 0);
    issue(0, IDLE, 0, 0, WORD, 0);
    checks++; if (lowcnt != 0) begin fails++; $display("FAIL zw_hready: low cycles %0d required 0", lowcnt); end
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL zw_count: reads %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e || e !== 32'hDEADBEEF) begin fails++; $display("FAIL zw_read: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_byte_lanes();
    logic [31:0] req [2];
    req[0] = 32'h00AB0000; req[1] = 32'h12340000;
    sel = 1'b0;
    issue(1, NONSEQ, 1, 32'h10, WORD, 32'h0);
    issue(1, NONSEQ, 1, 32'h12, BYTE, 32'h00AB0000);
    issue(1, NONSEQ, 0, 32'h10, WORD, 0);
    issue(1, NONSEQ, 1, 32'h13, HALF, 32'h12340000);
    issue(1, NONSEQ, 0, 32'h10, WORD, 0);
    issue(0, IDLE, 0, 0, WORD, 0);
    checks++; if (obs_q.size() != 2) begin fails++; $display("FAIL bl_count: reads %0d required 2", obs_q.size()); end
    for (int i = 0; i < 2 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e || o !== req[i]) begin fails++; $display("FAIL bl_read%0d: got %h required %h", i, o, req[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wait_states();
    int t0, t1;
    sel = 1'b1; hburst = INCR4;
    issue(1, NONSEQ, 1, 32'h40, WORD, 32'hCAFE0001);
    for (int i = 0; i < 4; i++)
      issue(1, i == 0 ? NONSEQ : SEQ, 1, 32'h50 + 32'(4*i), WORD, 32'hA5000000 + 32'(i));
    issue(0, IDLE, 0, 0, WORD, 0);
    lowcnt = 0;
    issue(1, NONSEQ, 0, 32'h40, WORD, 0);
    issue(0, IDLE, 0, 0, WORD, 0);
    checks++; if (lowcnt != 3) begin fails++; $display("FAIL ws_low: low cycles %0d required 3", lowcnt); end
    issue(1, NONSEQ, 0, 32'h50, WORD, 0);
    t0 = cyc;
    for (int i = 1; i < 4; i++) issue(1, SEQ, 0, 32'h50 + 32'(4*i), WORD, 0);
    issue(0, IDLE, 0, 0, WORD, 0);
    t1 = cyc;
    checks++; if (t1 - t0 != 16) begin fails++; $display("FAIL ws_burst_cycles: got %0d required 16", t1 - t0); end
    checks++; if (obs_q.size() != 5) begin fails++; $display("FAIL ws_count: reads %0d required 5", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL ws_read: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); hburst = SINGLE;
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      issue(1, NONSEQ, 1, 32'h60, WORD, 32'h0BAD0BAD);
      issue(0, IDLE, 0, 0, WORD, 0);
      issue(1, NONSEQ, 1, 32'h60, WORD, 32'h600D600D + 32'(s));
      issue(1, NONSEQ, 0, 32'h60, WORD, 0);
      issue(0, IDLE, 0, 0, WORD, 0);
      checks++; if (obs_q.size() != 1) begin fails++; $display("FAIL b2b_count%0d: reads %0d required 1", s, obs_q.size()); end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        logic [31:0] e, o;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if (o !== e || o !== 32'h600D600D + 32'(s)) begin fails++; $display("FAIL b2b_read%0d: got %h required %h", s, o, e); end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_idle_busy();
    sel = 1'b1; hburst = INCR;
    issue(1, NONSEQ, 1, 32'h88, WORD, 32'h88888888);
    issue(1, NONSEQ, 1, 32'h8C, WORD, 32'h8C8C8C8C);
    issue(0, IDLE, 0, 0, WORD, 0);
    lowcnt = 0;
    issue(1, NONSEQ, 1, 32'h80, WORD, 32'h11111111);
    issue(1, BUSY,   1, 32'h84, WORD, 32'hFFFFFFFF);
    issue(1, SEQ,    1, 32'h84, WORD, 32'h22222222);
    issue(1, IDLE,   1, 32'h88, WORD, 32'hEEEEEEEE);
    issue(0, NONSEQ, 1, 32'h8C, WORD, 32'hDDDDDDDD);
    issue(1, SEQ,    1, 32'h88, WORD, 32'h33333333);
    issue(0, IDLE, 0, 0, WORD, 0);
    checks++; if (lowcnt != 9) begin fails++; $display("FAIL ib_beats: low cycles %0d required 9", lowcnt); end
    for (int i = 0; i < 4; i++) issue(1, NONSEQ, 0, 32'h80 + 32'(4*i), WORD, 0);
    issue(0, IDLE, 0, 0, WORD, 0);
    checks++; if (obs_q.size() != 4) begin fails++; $display("FAIL ib_count: reads %0d required 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL ib_read: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); hburst = SINGLE;
  endtask

  task automatic test_wrap_reset();
    sel = 1'b0;
    issue(1, NONSEQ, 1, 32'h400, WORD, 32'h57A70000);
    issue(1, NONSEQ, 0, 32'h0, WORD, 0);
    issue(0, IDLE, 0, 0, WORD, 0);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e || o !== 32'h57A70000) begin fails++; $display("FAIL wrap_read: got %h required %h", o, e); end
    end else begin
      checks++; fails++; $display("FAIL wrap_count: reads %0d required 1", obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
    sel = 1'b1;
    issue(1, NONSEQ, 1, 32'h20, WORD, 32'h01D01D00);
    issue(0, IDLE, 0, 0, WORD, 0);
    // write accepted outside the model, then aborted by reset in its wait state
    hsel = 1; htrans = NONSEQ; hwrite = 1; haddr = 32'h20; hsize = WORD;
    @(posedge clk); #1;
    hsel = 0; htrans = IDLE; hwrite = 0; hwdata = 32'hBADBAD00;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (hready3 !== 1'b1) begin fails++; $display("FAIL rst_mid_hready: got %b required 1", hready3); end
    checks++; if (hrdata3 !== 32'h0) begin fails++; $display("FAIL rst_mid_hrdata: got %h required 0", hrdata3); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    pend_rd = 1'b0; pend_wd = '0;
    issue(1, NONSEQ, 0, 32'h20, WORD, 0);
    issue(0, IDLE, 0, 0, WORD, 0);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [31:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e || o !== 32'h01D01D00) begin fails++; $display("FAIL rst_old_value: got %h required %h", o, e); end
    end else begin
      checks++; fails++; $display("FAIL rst_count: reads %0d required 1", obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_byte_lanes();
    test_wait_states();
    test_back_to_back();
    test_idle_busy();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB-Lite subordinate (responder) with an internal word-addressed memory and a programmable number of wait states.
- It is the RTL counterpart driven by the master side of the AHB VIP interface (ahb_vif). It responds on hrdata/hready to haddr/htrans/hwrite/hsize/hburst/hsel/hwdata.
- Serves as the reference target in ahb2apb environment tests and as a scoreboard cross-check.
- No hresp/hexokay: every transfer completes OKAY.

Parameters:
AHB_DW, 32, data bus width in bits; 32 or 64 only.
AHB_AW, 32, address bus width in bits.
MEM_DEPTH, 256, memory depth in AHB_DW-wide words; power of two.
WAIT_STATES, 0, hready-low cycles inserted per transfer; range 0..15.

Ports:
clk  input  1  single clock; all logic on posedge.
reset_n  input  1  asynchronous, active-low reset.
hsel  input  1  subordinate select.
haddr  input  AHB_AW  byte address (address phase).
htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
hwrite  input  1  1=write, 0=read.
hsize  input  3  transfer size (log2 bytes).
hburst  input  3  burst type; informational only.
hwdata  input  AHB_DW  write data (data phase).
hrdata  output  AHB_DW  read data (data phase).
hready  output  1  transfer done / subordinate ready.

Behaviour:
- Reset (reset_n low, asynchronous): state=S_IDLE, hready=1, hrdata=0, wait counter=0, pending transfer cleared. Memory contents are not reset and are retained across reset.
- Valid address phase: sampled at a posedge where hsel=1, hready=1 and htrans[1]=1 (NONSEQ or SEQ).
  - On acceptance, register addr, hwrite and hsize into the data-phase registers.
- IDLE, BUSY or hsel=0 with hready=1: no transfer; the next cycle returns to or stays in S_IDLE, hready=1.
- State machine:
  - S_IDLE: hready=1.
    - Valid address phase: if WAIT_STATES=0 go to S_RESP; else go to S_WAIT with cnt=WAIT_STATES-1.
  - S_WAIT: hready=0; address-phase signals are ignored.
    - cnt=0: go to S_RESP.
    - Otherwise decrement cnt.
  - S_RESP: hready=1; final data-phase cycle.
    - A new valid address phase in the same cycle is accepted (pipelined) and routes as in S_IDLE.
    - Otherwise go to S_IDLE.
- Latency per transfer: data phase lasts WAIT_STATES+1 cycles. Back-to-back throughput is one transfer per WAIT_STATES+1 cycles.
- Word index = addr[log2(AHB_DW/8) +: log2(MEM_DEPTH)]. Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH words.
- Byte lanes are little-endian. Lane offset = addr[log2(AHB_DW/8)-1:0], masked to the alignment required by hsize (low bits forced to 0).
- hsize greater than log2(AHB_DW/8) is treated as full-width.
- Write: hwdata is sampled at the posedge ending S_RESP. Only enabled byte lanes are written; other bytes are unchanged.
- Read: hrdata is combinational from memory at the registered index, full word, all lanes. It is valid only while in S_RESP with the registered hwrite=0. hrdata=0 in all other cycles.
- Write followed by a read of the same word: the write commits before the read's data phase, so no bypass is needed for any WAIT_STATES.
- Reset asserted mid-transfer (S_WAIT or S_RESP before the edge): the pending write is discarded and memory is untouched.
- hburst is not decoded. Each beat's address comes from haddr, so INCR, WRAP and undefined-length bursts are handled identically.

Decomposition:
- Package ahb_pkg:
  - htrans_e (IDLE, BUSY, NONSEQ, SEQ)
  - hsize_e (BYTE, HALF, WORD, DWORD)
  - hburst_e (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16)
  - slave state enum (S_IDLE, S_WAIT, S_RESP)
- Sub-module ahb_wstrb_gen: combinational; inputs addr low bits and hsize; output AHB_DW/8 byte-enable vector. It is reused by the later APB bridge.

Test Plan:
1. Zero-wait word write/read (WAIT_STATES=0): NONSEQ write 0x10 data 0xDEADBEEF, then NONSEQ read 0x10 -> hready stays 1 throughout; hrdata=0xDEADBEEF in the read data-phase cycle.
2. Byte write: preload 0x10=0x00000000, hsize=0 write to 0x12 with hwdata=0x00AB0000 -> readback 0x00AB0000. Then a hsize=1 write to 0x13 (aligned to 0x12) with 0x12340000 -> readback 0x12340000.
3. Wait states (WAIT_STATES=3): single read -> hready low for exactly 3 cycles, then high for 1 with valid data. A back-to-back 4-beat INCR4 takes 16 cycles.
4. Pipelined write then read of the same address, with the read address phase in the write's S_RESP cycle -> the read returns the new data; no stale value.
5. IDLE/BUSY/hsel=0 cycles interleaved in an INCR burst -> no memory change; hready=1 on those cycles; beat count correct.
6. Address wrap plus reset: write to word index MEM_DEPTH (0x400 with default depth and width) -> aliases to index 0. Then assert reset_n low during S_WAIT of a write to 0x20 -> hready=1 and hrdata=0 immediately; a later read of 0x20 returns the old value.
